// File: rtl/multi_seq.sv
// multi_seq: sequences n extra register steps of a multi-register op; n+1 cycles from issue to next fetch.
// Define SEQ_IRQ_DEFER_EN to defer interrupts to the done cycle; otherwise an interrupt aborts the sequence.
module multi_seq (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       issue,
  input  logic [4:0] multi_in,
  input  logic [4:0] rc_base,
  input  logic       irq_in,
  output logic       stall,
  output logic       seq_valid,
  output logic [4:0] seq_reg,
  output logic [6:0] seq_ofs,
  output logic       irq_out,
  output logic       done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [4:0] k_q, k_d;
  logic [4:0] n_q, n_d;
  logic [4:0] base_q, base_d;
  logic       done_q, done_d;
  logic       pend_q, pend_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      k_q     <= 5'd0;
      n_q     <= 5'd0;
      base_q  <= 5'd0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      base_q  <= base_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
    end
  end

  // Every output is gated by reset_n so an asserted reset clears them at once, even mid-sequence.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    n_d       = n_q;
    base_d    = base_q;
    done_d    = 1'b0;
    pend_d    = pend_q;
    stall     = 1'b0;
    seq_valid = 1'b0;
    seq_reg   = 5'd0;
    seq_ofs   = 7'd0;
    irq_out   = 1'b0;
    done      = 1'b0;
    if (reset_n) begin
      done = done_q;
      if (state_q == IDLE) begin
`ifdef SEQ_IRQ_DEFER_EN
        irq_out = irq_in | pend_q;
        pend_d  = 1'b0;
`else
        irq_out = irq_in;
`endif
        if (issue && (multi_in != 5'd0)) begin
          stall   = 1'b1;
          n_d     = multi_in;
          base_d  = rc_base;
          k_d     = 5'd1;
          state_d = RUN;
        end
      end else begin
        seq_valid = 1'b1;
        seq_reg   = base_q + k_q;
        seq_ofs   = {k_q, 2'b00};
`ifdef SEQ_IRQ_DEFER_EN
        if (irq_in) pend_d = 1'b1;
        if (k_q < n_q) begin
          stall = 1'b1;
          k_d   = k_q + 5'd1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`else
        irq_out = irq_in;
        if (irq_in) begin
          // Abort: steps already stored stay stored, no done pulse.
          state_d = IDLE;
        end else if (k_q < n_q) begin
          stall = 1'b1;
          k_d   = k_q + 5'd1;
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: doc/multi_seq.md
MULTI_SEQ -- requirements
Module: multi_seq

Interface
REQ-001 SHALL have port: clk  input  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: issue  input  1  current instruction valid in decode this cycle.
REQ-004 SHALL have port: multi_in  input  5  extra-step count from the control decoder's multi field; 0 = single-cycle op.
REQ-005 SHALL have port: rc_base  input  5  first register of the multi-register op; captured at start.
REQ-006 SHALL have port: irq_in  input  1  raw interrupt request, level.
REQ-007 SHALL have port: stall  output  1  holds PC and IR when high.
REQ-008 SHALL have port: seq_valid  output  1  overrides ra2sel/mwr/address offset from the decoder when high.
REQ-009 SHALL have port: seq_reg  output  5  register index read for the current step.
REQ-010 SHALL have port: seq_ofs  output  7  byte offset added to the store address, = 4*step.
REQ-011 SHALL have port: irq_out  output  1  gated interrupt to the control decoder.
REQ-012 SHALL have port: done  output  1  one-cycle pulse after the last step completes.

Function
REQ-013 SHALL implement states IDLE and RUN, plus a 5-bit step counter k and a 5-bit registered count n.
REQ-014 In IDLE with issue=1 and multi_in!=0: stall SHALL be 1 combinationally in that cycle; at the edge, n<=multi_in, base<=rc_base, k<=1, state<=RUN.
REQ-015 In IDLE with issue=0 or multi_in=0: stall=0, state SHALL remain IDLE. Step 0 is the decoder's own cycle.
REQ-016 In RUN: seq_valid=1, seq_reg=(base+k) mod 32 (wraps 31->0), seq_ofs={k,2'b00}.
REQ-017 In RUN with k<n: stall=1; at the edge, k<=k+1.
REQ-018 In RUN with k==n (last step): stall=0 so PC advances at this edge; state<=IDLE; done SHALL be 1 in the following cycle only.
REQ-019 issue and multi_in SHALL be ignored while in RUN.
REQ-020 Outside RUN: seq_valid=0, seq_reg=0, seq_ofs=0.
REQ-021 In IDLE with no pending IRQ: irq_out=irq_in.
REQ-022 multi_in=31 SHALL give 31 RUN cycles, with seq_ofs reaching 124 and no counter overflow.
REQ-023 Total latency SHALL be n+1 cycles from issue to the next instruction fetch.

Reset
REQ-024 reset_n=0 SHALL immediately force IDLE with k=0, n=0, base=0, the pending-IRQ flag cleared, and all outputs 0 (irq_out follows REQ-021 after release), including mid-sequence.
REQ-025 Reset release SHALL be sampled synchronously; the first issue is accepted on the first edge after release.

Configuration
REQ-026 Macro SEQ_IRQ_DEFER_EN SHALL select interrupt handling during RUN.
- Defined: irq_out=0 in RUN. irq_in=1 in any RUN cycle sets a pending flag. irq_out=1 in the cycle after the last step (the done cycle), and the flag clears when irq_out is presented. A sequence is never broken.
- Undefined: irq_in=1 in RUN aborts the sequence. state<=IDLE at that edge, stall=0 in that cycle, no done pulse, and steps already stored are kept. irq_out=irq_in always.

Verification
REQ-027 issue=1, multi_in=7, rc_base=3 -> stall high 7 cycles; seq_reg 4..10, seq_ofs 4..28; done high at cycle 9 relative to issue at cycle 1.
REQ-028 multi_in=0 with issue=1 -> stall=0, seq_valid never asserted, done stays 0.
REQ-029 rc_base=30, multi_in=3 -> seq_reg 31, 0, 1; seq_ofs 4, 8, 12.
REQ-030 reset_n pulsed low at step 2 of multi_in=5 -> all outputs 0 asynchronously; next issue with multi_in=2 runs 2 clean steps.
REQ-031 With SEQ_IRQ_DEFER_EN, irq_in pulsed at step 3 of 7 -> irq_out 0 during RUN, 1 in the done cycle. Without the macro -> sequence aborts at step 3, seq_valid drops, done stays 0.
REQ-032 issue held high with multi_in=4 throughout RUN -> exactly one sequence of 4 steps, with no restart until back in IDLE.
